// File: rtl/lcg_pkg.sv
// Shared types for the LCG seed-recovery search: default data width,
// seed and wide-arithmetic word types, and the search controller states.
package lcg_pkg;

   localparam int DEFAULT_W = 32;

   typedef logic [DEFAULT_W-1:0] word_t;
   typedef logic [2*DEFAULT_W:0] dword_t;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CHECK  = 3'd1,
      S_STEP0  = 3'd2,
      S_STEP1  = 3'd3,
      S_STEP2  = 3'd4,
      S_NEXT   = 3'd5,
      S_FINISH = 3'd6
   } state_t;

endpackage

// File: rtl/lcg_seed_search_lcg_step.sv
// One combinational LCG step, (x*a + c) mod m, kept apart from the controller
// so a pipelined version can drop in later without touching the FSM.
module lcg_step
   import lcg_pkg::*;
#(
   parameter int W = DEFAULT_W
) (
   input  logic [W-1:0] i_x,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_c,
   input  logic [W-1:0] i_m,
   output logic [W-1:0] o_next
);

   logic [2*W-1:0] w_prod;
   logic [2*W:0]   w_sum;

   // Full-width product and sum; the modulus is the only narrowing step.
   // A zero modulus yields zero here and is rejected by the controller anyway.
   assign w_prod = {{W{1'b0}}, i_x} * {{W{1'b0}}, i_a};
   assign w_sum  = {1'b0, w_prod} + {{(W+1){1'b0}}, i_c};
   assign o_next = (i_m == '0) ? '0 : W'(w_sum % {{(W+1){1'b0}}, i_m});

endmodule

// File: rtl/lcg_seed_search.sv
// Brute-force LCG seed recovery: walks seed_lo..seed_hi through three shared steps.
// Optional LCG_SEARCH_MULTI_MATCH_EN reports every matching seed instead of stopping.
module lcg_seed_search
   import lcg_pkg::*;
#(
   parameter int W  = DEFAULT_W,
   parameter int CW = 32
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          start,
   input  logic [W-1:0]  seed_lo,
   input  logic [W-1:0]  seed_hi,
   input  logic [W-1:0]  modulus,
   input  logic [W-1:0]  multiplier,
   input  logic [W-1:0]  increment,
   input  logic [W-1:0]  target0,
   input  logic [W-1:0]  target1,
   input  logic [W-1:0]  target2,
   output logic          busy,
   output logic          done,
   output logic          found,
   output logic [W-1:0]  found_seed,
   output logic [CW-1:0] seeds_tried,
`ifdef LCG_SEARCH_MULTI_MATCH_EN
   output logic          match_valid,
   output logic [W-1:0]  match_seed,
`endif
   output logic          cfg_err
);

   state_t        r_state;
   logic [W-1:0]  r_lo, r_hi, r_m, r_a, r_c;
   logic [W-1:0]  r_t0, r_t1, r_t2;
   logic [W-1:0]  r_cur, r_x;
   logic          r_busy, r_done, r_found, r_cfg_err;
   logic [W-1:0]  r_found_seed;
   logic [CW-1:0] r_tried;
`ifdef LCG_SEARCH_MULTI_MATCH_EN
   logic          r_match_valid;
   logic [W-1:0]  r_match_seed;
`endif

   logic [W-1:0]  w_step;
   logic [W-1:0]  w_target;
   logic          w_hit;

   lcg_step #(.W(W)) u_step (
      .i_x   (r_x),
      .i_a   (r_a),
      .i_c   (r_c),
      .i_m   (r_m),
      .o_next(w_step)
   );

   always_comb begin
      w_target = r_t0;
      case (r_state)
         S_STEP1: w_target = r_t1;
         S_STEP2: w_target = r_t2;
         default: w_target = r_t0;
      endcase
   end

   assign w_hit = (w_step == w_target);

   // Controller; the step result lands in r_x every STEPk cycle regardless of outcome.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state      <= S_IDLE;
         r_lo         <= '0;
         r_hi         <= '0;
         r_m          <= '0;
         r_a          <= '0;
         r_c          <= '0;
         r_t0         <= '0;
         r_t1         <= '0;
         r_t2         <= '0;
         r_cur        <= '0;
         r_x          <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_found      <= 1'b0;
         r_found_seed <= '0;
         r_tried      <= '0;
         r_cfg_err    <= 1'b0;
`ifdef LCG_SEARCH_MULTI_MATCH_EN
         r_match_valid <= 1'b0;
         r_match_seed  <= '0;
`endif
      end else begin
         r_done <= 1'b0;
`ifdef LCG_SEARCH_MULTI_MATCH_EN
         r_match_valid <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_lo      <= seed_lo;
                  r_hi      <= seed_hi;
                  r_m       <= modulus;
                  r_a       <= multiplier;
                  r_c       <= increment;
                  r_t0      <= target0;
                  r_t1      <= target1;
                  r_t2      <= target2;
                  r_found   <= 1'b0;
                  r_cfg_err <= 1'b0;
                  r_tried   <= '0;
                  r_busy    <= 1'b1;
                  r_state   <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (r_m == '0) begin
                  r_cfg_err <= 1'b1;
                  r_state   <= S_FINISH;
               end else if (r_lo > r_hi) begin
                  r_state <= S_FINISH;
               end else begin
                  r_cur   <= r_lo;
                  r_x     <= r_lo;
                  r_tried <= r_tried + CW'(1);
                  r_state <= S_STEP0;
               end
            end
            S_STEP0: begin
               r_x     <= w_step;
               r_state <= w_hit ? S_STEP1 : S_NEXT;
            end
            S_STEP1: begin
               r_x     <= w_step;
               r_state <= w_hit ? S_STEP2 : S_NEXT;
            end
            S_STEP2: begin
               r_x <= w_step;
               if (!w_hit) begin
                  r_state <= S_NEXT;
               end else begin
`ifdef LCG_SEARCH_MULTI_MATCH_EN
                  if (!r_found) begin
                     r_found      <= 1'b1;
                     r_found_seed <= r_cur;
                  end
                  r_match_valid <= 1'b1;
                  r_match_seed  <= r_cur;
                  r_state       <= S_NEXT;
`else
                  r_found      <= 1'b1;
                  r_found_seed <= r_cur;
                  r_state      <= S_FINISH;
`endif
               end
            end
            S_NEXT: begin
               // Compare before incrementing so an all-ones seed_hi never wraps.
               if (r_cur == r_hi) begin
                  r_state <= S_FINISH;
               end else begin
                  r_cur   <= r_cur + W'(1);
                  r_x     <= r_cur + W'(1);
                  r_tried <= r_tried + CW'(1);
                  r_state <= S_STEP0;
               end
            end
            S_FINISH: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign found       = r_found;
   assign found_seed  = r_found_seed;
   assign seeds_tried = r_tried;
   assign cfg_err     = r_cfg_err;
`ifdef LCG_SEARCH_MULTI_MATCH_EN
   assign match_valid = r_match_valid;
   assign match_seed  = r_match_seed;
`endif

endmodule

// File: tb/tb_lcg_seed_search.sv
// Self-checking bench for lcg_seed_search: directed scenarios plus random searches
// against a loop-based reference of the seed walk and its per-seed cycle cost.
module tb_lcg_seed_search;

   logic        CLK = 1'b0;
   logic        RST;
   logic        start;
   logic [31:0] seed_lo, seed_hi, modulus, multiplier, increment;
   logic [31:0] target0, target1, target2;
   logic        busy, done, found, cfg_err;
   logic [31:0] found_seed;
   logic [31:0] seeds_tried;
`ifdef LCG_SEARCH_MULTI_MATCH_EN
   logic        match_valid;
   logic [31:0] match_seed;
   int          matchCount;
`endif

   int checkCount = 0;
   int errorCount = 0;

   always #5 CLK = ~CLK;

   lcg_seed_search #(.W(32), .CW(32)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .start      (start),
      .seed_lo    (seed_lo),
      .seed_hi    (seed_hi),
      .modulus    (modulus),
      .multiplier (multiplier),
      .increment  (increment),
      .target0    (target0),
      .target1    (target1),
      .target2    (target2),
      .busy       (busy),
      .done       (done),
      .found      (found),
      .found_seed (found_seed),
      .seeds_tried(seeds_tried),
`ifdef LCG_SEARCH_MULTI_MATCH_EN
      .match_valid(match_valid),
      .match_seed (match_seed),
`endif
      .cfg_err    (cfg_err)
   );

`ifdef LCG_SEARCH_MULTI_MATCH_EN
   always @(posedge CLK) if (match_valid) matchCount++;
`endif

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      if (obs !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] lcgNext(input logic [31:0] x, a, c, m);
      logic [64:0] s;
      if (m == 0) return 32'd0;
      s = 65'(x) * 65'(a) + 65'(c);
      return 32'(s % 65'(m));
   endfunction

   // Reference: walk seeds with plain loops, adding the documented cost per seed.
   task automatic modelSearch(output logic mFound, output logic [31:0] mSeed,
                              output int mTried, output int mCycles,
                              output logic mCfg, output int mMatches);
      logic [31:0] x;
      logic [31:0] t [3];
      int          k;
      mFound = 0; mSeed = 0; mTried = 0; mCfg = 0; mMatches = 0;
      mCycles = 2;
      t[0] = target0; t[1] = target1; t[2] = target2;
      if (modulus == 0) begin
         mCfg = 1;
         return;
      end
      for (longint s = longint'(seed_lo); s <= longint'(seed_hi); s++) begin
         mTried++;
         x = 32'(s);
         k = 0;
         while (k < 3) begin
            x = lcgNext(x, multiplier, increment, modulus);
            if (x != t[k]) break;
            k++;
         end
         if (k < 3) begin
            mCycles += k + 2;
         end else begin
            mMatches++;
            if (!mFound) begin
               mFound = 1;
               mSeed  = 32'(s);
            end
`ifdef LCG_SEARCH_MULTI_MATCH_EN
            mCycles += 4;
`else
            mCycles += 3;
            break;
`endif
         end
      end
   endtask

   task automatic applyStimulus(input logic [31:0] lo, hi, m, a, c, t0, t1, t2);
      seed_lo = lo; seed_hi = hi; modulus = m; multiplier = a; increment = c;
      target0 = t0; target1 = t1; target2 = t2;
   endtask

   task automatic runSearch(input string tag, input bit disturb);
      logic        mFound, mCfg;
      logic [31:0] mSeed;
      int          mTried, mCycles, mMatches, cyc;
      modelSearch(mFound, mSeed, mTried, mCycles, mCfg, mMatches);
      if (mCycles < 8) disturb = 0;
`ifdef LCG_SEARCH_MULTI_MATCH_EN
      matchCount = 0;
`endif
      @(negedge CLK); start = 1'b1;
      @(posedge CLK); #1; start = 1'b0;
      checkOutput({tag, ".busy_on"}, 64'(busy), 64'd1);
      checkOutput({tag, ".cleared"}, {found, cfg_err, seeds_tried}, 64'd0);
      cyc = 0;
      while (!done && cyc < 2000) begin
         @(posedge CLK); #1; cyc++;
         if (disturb && cyc == 3) begin
            applyStimulus($urandom, $urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom);
            start = 1'b1;
         end
         if (disturb && cyc == 4) start = 1'b0;
      end
      checkOutput({tag, ".done_seen"}, 64'(done), 64'd1);
      checkOutput({tag, ".latency"}, 64'(cyc), 64'(mCycles));
      checkOutput({tag, ".found"}, 64'(found), 64'(mFound));
      if (mFound) checkOutput({tag, ".found_seed"}, 64'(found_seed), 64'(mSeed));
      checkOutput({tag, ".seeds_tried"}, 64'(seeds_tried), 64'(mTried));
      checkOutput({tag, ".cfg_err"}, 64'(cfg_err), 64'(mCfg));
      checkOutput({tag, ".busy_off"}, 64'(busy), 64'd0);
      @(posedge CLK); #1;
      checkOutput({tag, ".done_pulse"}, 64'(done), 64'd0);
`ifdef LCG_SEARCH_MULTI_MATCH_EN
      checkOutput({tag, ".matches"}, 64'(matchCount), 64'(mMatches));
`endif
   endtask

   task automatic scenarioOne();
      applyStimulus(32'd0, 32'd200, 32'd993441, 32'd4001, 32'd60211,
                    32'd444307, 32'd466569, 32'd127141);
   endtask

   initial begin
      logic [31:0] s, span, m;
      bit          quiet;
      RST = 1'b1;
      start = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge CLK);
      #1;
      checkOutput("reset.outputs", {busy, done, found, cfg_err, seeds_tried}, 64'd0);
      checkOutput("reset.found_seed", 64'(found_seed), 64'd0);
      @(negedge CLK); RST = 1'b0;

      scenarioOne();
      runSearch("s1", 0);
      checkOutput("s1.seed96", 64'(found_seed), 64'd96);
      checkOutput("s1.tried97", 64'(seeds_tried), 64'd97);

      applyStimulus(32'd90, 32'd99, 32'd993441, 32'd4001, 32'd60211, 32'd1, 32'd2, 32'd3);
      runSearch("nomatch", 0);

      applyStimulus(32'd5, 32'd4, 32'd993441, 32'd4001, 32'd60211, 32'd1, 32'd2, 32'd3);
      runSearch("empty", 0);

      applyStimulus(32'd0, 32'd10, 32'd0, 32'd4001, 32'd60211, 32'd1, 32'd2, 32'd3);
      runSearch("modzero", 0);

      applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd993441, 32'd4001, 32'd60211,
                    32'd1, 32'd2, 32'd3);
      runSearch("topseed", 0);

      // Reset while the matching seed 96 is in its second step.
      scenarioOne();
      seed_lo = 32'd96;
      @(negedge CLK); start = 1'b1;
      @(posedge CLK); #1; start = 1'b0;
      @(posedge CLK);
      @(posedge CLK); #2;
      checkOutput("abort.busy_before", 64'(busy), 64'd1);
      RST = 1'b1;
      #1;
      checkOutput("abort.outputs", {busy, done, found, cfg_err, seeds_tried}, 64'd0);
      checkOutput("abort.found_seed", 64'(found_seed), 64'd0);
      @(negedge CLK); RST = 1'b0;
      quiet = 1;
      repeat (10) begin
         @(posedge CLK); #1;
         if (done || busy) quiet = 0;
      end
      checkOutput("abort.no_done", 64'(quiet), 64'd1);

      scenarioOne();
      runSearch("rerun", 1);
      checkOutput("rerun.seed96", 64'(found_seed), 64'd96);

      for (int i = 0; i < 12; i++) begin
         span = $urandom_range(0, 20);
         s = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + $urandom_range(0, 15)
                                        : $urandom_range(0, 5000);
         m = ($urandom_range(0, 2) == 0) ? $urandom : $urandom_range(1, 100000);
         applyStimulus(s, s + span, m, $urandom, $urandom, $urandom, $urandom, $urandom);
         if ($urandom_range(0, 1) == 1) begin
            s = seed_lo + $urandom_range(0, span);
            target0 = lcgNext(s, multiplier, increment, modulus);
            target1 = lcgNext(target0, multiplier, increment, modulus);
            target2 = lcgNext(target1, multiplier, increment, modulus);
            if ($urandom_range(0, 2) == 0) target2 = target2 ^ 32'h1;
         end
         runSearch($sformatf("rand%0d", i), i[0]);
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/lcg_seed_search.md
Name: lcg_seed_search

Overview:
- Brute-force seed-recovery controller built around one shared LCG step datapath.
- Walks candidate seeds from seed_lo to seed_hi. For each seed it sequences three LCG steps X(n+1) = (X(n)*a + c) mod m.
- Each step result is compared against three observed target outputs; a seed is rejected at the first mismatching step.
- Reports the first matching seed and the number of seeds tried. Sits between host/config registers and the lcg_step datapath.

Parameters:
- W, 32, data width of seeds, modulus, multiplier, increment and targets.
- CW, 32, width of the seeds_tried counter.

Ports:
- CLK  in  1  system clock; all state on rising edge
- RST  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins a search when idle
- seed_lo  in  W  first candidate seed, inclusive
- seed_hi  in  W  last candidate seed, inclusive
- modulus  in  W  m
- multiplier  in  W  a
- increment  in  W  c
- target0  in  W  expected first output
- target1  in  W  expected second output
- target2  in  W  expected third output
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at search end
- found  out  1  a matching seed exists; valid from done until the next start
- found_seed  out  W  matching seed; valid when found
- seeds_tried  out  CW  number of seeds evaluated in the current/last search
- cfg_err  out  1  modulus == 0 at start; valid from done until the next start

Behaviour:
- Reset values: busy=0, done=0, found=0, found_seed=0, seeds_tried=0, cfg_err=0; FSM in IDLE.
- Reset mid-search aborts immediately with no done pulse.
- Start acceptance: start is accepted only in IDLE. start while busy is ignored.
- On accept, all config and target inputs are latched. Input changes during a search have no effect.
- On accept, found, cfg_err and seeds_tried are cleared.
- FSM states: IDLE, CHECK, STEP0, STEP1, STEP2, NEXT, FINISH.
- IDLE --start--> CHECK.
- CHECK:
  - modulus==0: cfg_err<=1 --> FINISH.
  - seed_lo>seed_hi: --> FINISH with found=0, seeds_tried=0.
  - otherwise: cur<=seed_lo, x<=seed_lo --> STEP0.
- STEPk (k=0..2):
  - x <= step(x). The comparison uses the combinational step result against target k.
  - On mismatch: --> NEXT.
  - On match with k<2: --> STEP(k+1).
  - On match with k==2: found<=1, found_seed<=cur --> FINISH.
  - seeds_tried increments on entry to STEP0 for each seed.
- NEXT:
  - cur==seed_hi: --> FINISH.
  - otherwise: cur<=cur+1, x<=cur+1 --> STEP0.
  - cur is compared before incrementing, so seed_hi = 2^W-1 terminates without wrap.
- FINISH: done=1 for one cycle, busy<=0 --> IDLE.
- Timing: 2 cycles per seed rejected at step 0, 3 per rejected at step 1, 4 per rejected at step 2.
- Arithmetic:
  - Product x*a is formed at 2W bits and the increment is added at 2W+1 bits.
  - The remainder mod m is then reduced to W bits; no truncation before the mod.
  - Step latency is single-cycle combinational into the x register. Targets are compared exactly, not reduced mod m.

Optional Feature:
- Macro: LCG_SEARCH_MULTI_MATCH_EN.
- With the macro:
  - Adds output ports match_valid (1) and match_seed (W).
  - On each full match, match_valid pulses for one cycle with match_seed=cur.
  - The FSM then goes to NEXT rather than FINISH, so the search runs to seed_hi.
  - found/found_seed hold the first match.
- Without the macro: ports are absent and the search stops at the first match.

Decomposition:
- Package lcg_pkg:
  - W default.
  - Typedefs word_t (W) and dword_t (2W+1).
  - FSM state enum.
- Sub-module lcg_step: combinational x, a, c, m -> (x*a+c) mod m.
  - Instantiated once; the seed_search FSM owns the x register.
  - Kept separate so it can later be pipelined.

Test Plan:
- m=993441, a=4001, c=60211, targets 444307/466569/127141, seed range 0..200, start.
  -> found=1, found_seed=96, seeds_tried=97, done within 200 cycles.
- Same config, targets 1/2/3, seed range 90..99.
  -> done, found=0, seeds_tried=10, no match pulse.
- seed_lo=5, seed_hi=4.
  -> done 2 cycles after start, found=0, seeds_tried=0.
- modulus=0.
  -> cfg_err=1, found=0, done 2 cycles after start.
- seed_lo=seed_hi=0xFFFFFFFF with non-matching targets.
  -> terminates, seeds_tried=1, no wrap to 0.
- Assert RST during STEP1; change inputs and pulse start mid-search.
  - On reset: all outputs return to reset values immediately and there is no done pulse.
  - Re-run the first scenario: identical result.
  - A mid-search start pulse is ignored, and input changes mid-search do not alter the result.
